// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if
// Groups the producer-side push bus and the transmitter-side start/busy
// handshake of uart_tx_feeder into one bundle.
//
//   wr_en / wr_data      push request and byte (producer -> feeder)
//   full / empty / count FIFO occupancy status (feeder -> producer)
//   overflow/launch_err  sticky error flags (feeder -> producer)
//   clr_err              synchronous clear of both error flags
//   tx_start / tx_data   one-cycle start pulse and held byte (feeder -> UART)
//   tx_busy              transmitter busy flag (UART -> feeder)
//
// master : the environment around the feeder (producer plus transmitter)
// slave  : the feeder itself
// -----------------------------------------------------------------------------
interface uart_tx_feeder_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  launch_err;
  logic                  clr_err;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_busy;

  modport master (
    output wr_en, wr_data, clr_err, tx_busy,
    input  full, empty, count, overflow, launch_err, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, clr_err, tx_busy,
    output full, empty, count, overflow, launch_err, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Byte FIFO in front of a UART transmitter. Producers push bytes at full clock
// rate; the feeder pops one byte at a time, issues a one-cycle tx_start with the
// byte on tx_data, and paces itself on the transmitter's tx_busy flag. A launch
// that never sees tx_busy rise within BUSY_TIMEOUT cycles is abandoned and
// flagged on launch_err.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_feeder_if.slave (push bus, status, errors, tx handshake)
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_feeder_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  launch_err_q, launch_err_d;

  // Launch sequencer
  state_t                state_q;
  logic                  tx_start_q;
  logic [7:0]            tx_data_q;
  logic [TO_W-1:0]       to_cnt_q;

  logic                  full_w;
  logic                  empty_w;
  logic                  push;
  logic                  pop;
  logic                  timeout;

  // Status is decoded from the registered count, so a push while full is
  // rejected even when a pop frees a slot at the same edge.
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  assign push    = bus.wr_en && !full_w;
  assign pop     = (state_q == IDLE) && !empty_w && !bus.tx_busy;
  assign timeout = (state_q == WAIT_BUSY) && !bus.tx_busy &&
                   (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new error event in the same cycle as clr_err keeps the flag set.
    overflow_d   = (overflow_q   && !bus.clr_err) || (bus.wr_en && full_w);
    launch_err_d = (launch_err_q && !bus.clr_err) || timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      launch_err_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      launch_err_q <= launch_err_d;
    end
  end

  // Byte storage carries no reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      to_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start_q <= 1'b0;
          to_cnt_q   <= '0;
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Abandoned bytes are not retried; the next queued byte goes next.
          if (bus.tx_busy)  state_q  <= WAIT_DONE;
          else if (timeout) state_q  <= IDLE;
          else              to_cnt_q <= to_cnt_q + TO_W'(1);
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.launch_err = launch_err_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Directed bench for uart_tx_feeder. A transaction-level model (byte queue plus
// launch bookkeeping by edge number) predicts every output each cycle; literal
// checks pin latency, ordering, spacing, overflow and timeout behaviour.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int BT    = 4;

  logic clk;
  logic rst_n;
  logic busy_hold;
  logic xmt_busy;
  bit   ack_en;
  int   hold;
  bit   run;

  int checks;
  int errors;
  int cyc;

  logic [7:0] seen[$];
  int         seen_cyc[$];

  // model state
  logic [7:0] mq[$];
  bit         m_free;
  bit         m_acked;
  int         m_L;
  int         m_n;
  bit         m_start;
  logic [7:0] m_data;
  bit         m_ovf;
  bit         m_err;
  bit         do_pop, do_push, set_ovf, set_err, free_nxt;
  int         d;

  logic [7:0] exp_burst [3];

  uart_tx_feeder_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_tx_feeder #(.DEPTH_LOG2(DL2), .BUSY_TIMEOUT(BT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.tx_busy = xmt_busy | busy_hold;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_seen(input int n, input int budget, input string nm);
    int i;
    i = 0;
    while (seen.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk({nm, "_arrived"}, 32'(seen.size() >= n), 32'd1);
  endtask

  // Transmitter stand-in: raises busy the cycle after a start pulse and holds
  // it for 'hold' cycles. Unaffected by the feeder's reset.
  initial begin
    xmt_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ack_en && bus.tx_start) begin
        @(posedge clk);
        #1 xmt_busy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 xmt_busy = 1'b0;
      end
    end
  end

  // Launch log taken from the DUT for the literal ordering/timing checks.
  always @(negedge clk) begin
    if (rst_n && bus.tx_start) begin
      seen.push_back(bus.tx_data);
      seen_cyc.push_back(cyc);
    end
  end

  // Behavioural model: a queue of accepted bytes; a launch may happen when
  // bytes are queued, the transmitter is idle and the previous launch has been
  // resolved (busy seen and fallen, or timed out BT edges after the start
  // cycle). Edge index m_n measures time since the launch edge m_L.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_free  = 1'b1;
      m_acked = 1'b0;
      m_L     = 0;
      m_n     = 0;
      m_start = 1'b0;
      m_data  = 8'h00;
      m_ovf   = 1'b0;
      m_err   = 1'b0;
    end else begin
      do_pop   = (mq.size() > 0) && m_free && !bus.tx_busy;
      do_push  = bus.wr_en && (mq.size() < DEPTH);
      set_ovf  = bus.wr_en && (mq.size() == DEPTH);
      set_err  = 1'b0;
      free_nxt = m_free;
      if (!m_free) begin
        d = m_n - m_L;
        if (!m_acked) begin
          if (d >= 2) begin
            if (bus.tx_busy) m_acked = 1'b1;
            else if (d == 1 + BT) begin
              set_err  = 1'b1;
              free_nxt = 1'b1;
            end
          end
        end else if (!bus.tx_busy) begin
          free_nxt = 1'b1;
        end
      end
      m_start = do_pop;
      if (do_pop) begin
        m_data   = mq.pop_front();
        free_nxt = 1'b0;
        m_acked  = 1'b0;
        m_L      = m_n;
      end
      if (do_push) mq.push_back(bus.wr_data);
      m_ovf  = set_ovf || (m_ovf && !bus.clr_err);
      m_err  = set_err || (m_err && !bus.clr_err);
      m_free = free_nxt;
      m_n++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && run) begin
      chk("cmp_tx_start",   32'(bus.tx_start),   32'(m_start));
      chk("cmp_tx_data",    32'(bus.tx_data),    32'(m_data));
      chk("cmp_count",      32'(bus.count),      32'(mq.size()));
      chk("cmp_empty",      32'(bus.empty),      32'(mq.size() == 0));
      chk("cmp_full",       32'(bus.full),       32'(mq.size() == DEPTH));
      chk("cmp_overflow",   32'(bus.overflow),   32'(m_ovf));
      chk("cmp_launch_err", 32'(bus.launch_err), 32'(m_err));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, base2, k, L;
    exp_burst[0] = 8'h41;
    exp_burst[1] = 8'h42;
    exp_burst[2] = 8'h43;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    run         = 1'b0;
    rst_n       = 1'b0;
    busy_hold   = 1'b0;
    ack_en      = 1'b1;
    hold        = 1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_err = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",      32'(bus.count),      32'd0);
    chk("rst_empty",      32'(bus.empty),      32'd1);
    chk("rst_full",       32'(bus.full),       32'd0);
    chk("rst_tx_start",   32'(bus.tx_start),   32'd0);
    chk("rst_tx_data",    32'(bus.tx_data),    32'h00);
    chk("rst_overflow",   32'(bus.overflow),   32'd0);
    chk("rst_launch_err", 32'(bus.launch_err), 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;
    tick();

    // single byte: start pulse one edge after the push edge
    hold = 1;
    base = seen.size();
    push(8'h53);
    k = cyc;
    @(negedge clk);
    chk("single_empty_after_push", 32'(bus.empty), 32'd0);
    chk("single_count_after_push", 32'(bus.count), 32'd1);
    tick();
    @(negedge clk);
    chk("single_start", 32'(bus.tx_start), 32'd1);
    chk("single_data",  32'(bus.tx_data),  32'h53);
    tick();
    @(negedge clk);
    chk("single_start_one_cycle", 32'(bus.tx_start), 32'd0);
    wait_seen(base + 1, 50, "single");
    if (seen.size() >= base + 1)
      chk("single_latency", 32'(seen_cyc[base] - k), 32'd1);
    repeat (10) tick();
    chk("single_count_drained", 32'(bus.count), 32'd0);
    chk("single_empty_drained", 32'(bus.empty), 32'd1);

    // burst ordering and spacing (busy for 10 cycles -> 13-edge spacing)
    hold = 10;
    base = seen.size();
    push(8'h41);
    push(8'h42);
    push(8'h43);
    wait_seen(base + 3, 200, "burst");
    if (seen.size() >= base + 3) begin
      for (int i = 0; i < 3; i++)
        chk("burst_order", 32'(seen[base + i]), 32'(exp_burst[i]));
      for (int i = 1; i < 3; i++)
        chk("burst_spacing", 32'(seen_cyc[base + i] - seen_cyc[base + i - 1]), 32'd13);
    end
    repeat (15) tick();

    // full / overflow with the transmitter held busy
    busy_hold = 1'b1;
    hold      = 2;
    tick();
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    @(negedge clk);
    chk("full_flag",        32'(bus.full),     32'd1);
    chk("full_count",       32'(bus.count),    32'd16);
    chk("full_no_overflow", 32'(bus.overflow), 32'd0);
    push(8'h70);
    @(negedge clk);
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count),    32'd16);
    bus.clr_err = 1'b1;
    push(8'h71);
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("ovf_set_beats_clr", 32'(bus.overflow), 32'd1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    busy_hold = 1'b0;
    base = seen.size();
    wait_seen(base + 16, 400, "drain");
    if (seen.size() >= base + 16)
      for (int i = 0; i < 16; i++)
        chk("drain_order", 32'(seen[base + i]), 32'(8'(8'h60 + i)));
    repeat (20) tick();
    chk("drain_no_extra", 32'(seen.size()), 32'(base + 16));
    chk("drain_count",    32'(bus.count),   32'd0);

    // pointer wrap: 40 bytes through a 16-deep FIFO
    hold = 1;
    base = seen.size();
    for (int i = 0; i < 40; i++) begin
      push(8'(i));
      tick();
      tick();
    end
    wait_seen(base + 40, 400, "wrap");
    if (seen.size() >= base + 40)
      for (int i = 0; i < 40; i++)
        chk("wrap_order", 32'(seen[base + i]), 32'(i));
    repeat (10) tick();
    chk("wrap_count", 32'(bus.count), 32'd0);

    // launch timeout: no acknowledgement from the transmitter
    ack_en = 1'b0;
    base = seen.size();
    push(8'hA1);
    push(8'hA2);
    wait_seen(base + 1, 20, "to_first");
    L = (seen.size() >= base + 1) ? seen_cyc[base] : cyc;
    while (cyc < L + 4) tick();
    @(negedge clk);
    chk("to_err_not_yet", 32'(bus.launch_err), 32'd0);
    tick();
    @(negedge clk);
    chk("to_err_set", 32'(bus.launch_err), 32'd1);
    wait_seen(base + 2, 20, "to_next");
    if (seen.size() >= base + 2) begin
      chk("to_next_spacing", 32'(seen_cyc[base + 1] - L), 32'd6);
      chk("to_next_data",    32'(seen[base + 1]),         32'hA2);
    end
    repeat (10) tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", 32'(bus.launch_err), 32'd0);
    ack_en = 1'b1;
    tick();

    // asynchronous reset while a frame is in flight with 5 bytes queued
    hold = 20;
    base = seen.size();
    for (int i = 0; i < 6; i++) push(8'(8'h90 + i));
    tick();
    tick();
    chk("arst_pre_count",   32'(bus.count),   32'd5);
    chk("arst_pre_launches", 32'(seen.size()), 32'(base + 1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("arst_count",    32'(bus.count),    32'd0);
    chk("arst_empty",    32'(bus.empty),    32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base2 = seen.size();
    repeat (30) tick();
    chk("arst_no_launch", 32'(seen.size()), 32'(base2));
    hold = 1;
    push(8'h77);
    wait_seen(base2 + 1, 30, "arst_relaunch");
    if (seen.size() >= base2 + 1)
      chk("arst_relaunch_data", 32'(seen[base2]), 32'h77);
    repeat (10) tick();

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
